// File: rtl/harmonic_mixer_pkg.sv
// Shared widths, state encoding and constants for the harmonic mixer and
// its downstream output/filter stages.
package harmonic_mixer_pkg;

    localparam int SAMPLE_W = 16;
    localparam int HARM_W   = 8;
    localparam int LEVEL_W  = 8;
    localparam int ACC_W    = 32;

    localparam logic [LEVEL_W-1:0] LEVEL_INIT = 8'd255;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_READY = 3'd1,
        WAIT_LUT   = 3'd2,
        MAC        = 3'd3,
        ADVANCE    = 3'd4,
        OUTPUT     = 3'd5
    } state_t;

endpackage

// File: rtl/harmonic_mixer_mix_saturate.sv
// Combinational arithmetic right shift of the accumulator followed by signed
// saturation to the 16-bit sample range.
module mix_saturate
    import harmonic_mixer_pkg::*;
#(
    parameter int SHIFT = 8
) (
    input  logic signed [ACC_W-1:0]    acc,
    output logic signed [SAMPLE_W-1:0] mix
);

    localparam logic signed [ACC_W-1:0] POS_LIMIT = 32'sd32767;
    localparam logic signed [ACC_W-1:0] NEG_LIMIT = -32'sd32768;

    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = acc >>> SHIFT;
        if (shifted > POS_LIMIT) begin
            mix = 16'sh7FFF;
        end else if (shifted < NEG_LIMIT) begin
            mix = 16'sh8000;
        end else begin
            mix = shifted[SAMPLE_W-1:0];
        end
    end

endmodule

// File: rtl/harmonic_mixer.sv
// Per-tick sequencer: walks the upstream sine stage through harmonics 0..last,
// accumulates each value scaled by a decaying level, emits one saturated mix.
module harmonic_mixer
    import harmonic_mixer_pkg::*;
#(
    parameter int ACC_SHIFT    = 8,
    parameter int MAX_HARMONIC = 255
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_sample_tick,
    input  logic [HARM_W-1:0]   i_harmonic_count,
    input  logic [LEVEL_W-1:0]  i_decay,
    input  logic                i_sample_ready,
    input  logic [SAMPLE_W-1:0] i_sample_value,
    output logic [HARM_W-1:0]   o_harmonic,
    output logic                o_next_sample,
    output logic [SAMPLE_W-1:0] o_mix,
    output logic                o_mix_valid,
    output logic                o_busy,
    output logic                o_overrun
);

    localparam logic [HARM_W-1:0] MAX_H = MAX_HARMONIC[HARM_W-1:0];

    state_t state;
    state_t next_state;

    logic [HARM_W-1:0]          last;
    logic [LEVEL_W-1:0]         decay_q;
    logic [LEVEL_W-1:0]         level;
    logic signed [SAMPLE_W-1:0] sample_q;
    logic signed [ACC_W-1:0]    acc;
    logic signed [SAMPLE_W-1:0] mix_sat;

    // 16-bit signed times 9-bit non-negative level; magnitude stays within 24 bits.
    logic signed [SAMPLE_W+LEVEL_W:0] product;
    logic signed [ACC_W-1:0]          product_ext;

    always_comb begin
        product     = sample_q * $signed({1'b0, level});
        product_ext = {{(ACC_W-SAMPLE_W-LEVEL_W-1){product[SAMPLE_W+LEVEL_W]}}, product};
    end

    mix_saturate #(
        .SHIFT (ACC_SHIFT)
    ) u_mix_saturate (
        .acc (acc),
        .mix (mix_sat)
    );

    always_comb begin
        next_state    = state;
        o_next_sample = 1'b0;
        case (state)
            IDLE:       if (i_sample_tick) next_state = WAIT_READY;
            WAIT_READY: if (i_sample_ready) next_state = WAIT_LUT;
            WAIT_LUT:   next_state = MAC;
            MAC:        next_state = ADVANCE;
            ADVANCE: begin
                o_next_sample = 1'b1;
                next_state    = (o_harmonic == last) ? OUTPUT : WAIT_READY;
            end
            OUTPUT:     next_state = IDLE;
            default:    next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            last        <= '0;
            decay_q     <= '0;
            level       <= '0;
            sample_q    <= '0;
            acc         <= '0;
            o_harmonic  <= '0;
            o_mix       <= '0;
            o_mix_valid <= 1'b0;
            o_busy      <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            state       <= next_state;
            o_mix_valid <= 1'b0;
            // Ticks outside IDLE never touch frame control; they are only flagged.
            o_overrun   <= i_sample_tick && (state != IDLE);
            case (state)
                IDLE: begin
                    if (i_sample_tick) begin
                        last    <= (i_harmonic_count > MAX_H) ? MAX_H : i_harmonic_count;
                        decay_q <= i_decay;
                        acc     <= '0;
                        level   <= LEVEL_INIT;
                        o_busy  <= 1'b1;
                    end
                end
                WAIT_LUT: sample_q <= i_sample_value;
                MAC:      acc <= acc + product_ext;
                ADVANCE: begin
                    // Every harmonic is stepped even at zero level to keep upstream phases coherent.
                    o_harmonic <= (o_harmonic == last) ? '0 : o_harmonic + 1'b1;
                    level      <= (level > decay_q) ? level - decay_q : '0;
                end
                OUTPUT: begin
                    o_mix       <= mix_sat;
                    o_mix_valid <= 1'b1;
                    o_busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_harmonic_mixer.sv
// Directed bench for harmonic_mixer with an upstream handshake model and a
// queue-based scoreboard for mixed samples and harmonic stepping.
module tb_harmonic_mixer;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_sample_tick;
    logic [7:0]  i_harmonic_count;
    logic [7:0]  i_decay;
    logic        i_sample_ready;
    logic [15:0] i_sample_value;
    logic [7:0]  o_harmonic;
    logic        o_next_sample;
    logic [15:0] o_mix;
    logic        o_mix_valid;
    logic        o_busy;
    logic        o_overrun;

    int errors = 0;
    int checks = 0;
    int valid_cnt = 0;
    int overrun_cnt = 0;

    logic [15:0] exp_q[$];
    logic [7:0]  harm_q[$];

    logic [15:0] cur_value;
    logic        up_ready;
    logic        up_valid;
    int          up_cnt;

    always #5 clk = ~clk;

    harmonic_mixer dut (
        .i_clock          (clk),
        .i_reset          (rst),
        .i_sample_tick    (i_sample_tick),
        .i_harmonic_count (i_harmonic_count),
        .i_decay          (i_decay),
        .i_sample_ready   (i_sample_ready),
        .i_sample_value   (i_sample_value),
        .o_harmonic       (o_harmonic),
        .o_next_sample    (o_next_sample),
        .o_mix            (o_mix),
        .o_mix_valid      (o_mix_valid),
        .o_busy           (o_busy),
        .o_overrun        (o_overrun)
    );

    // Upstream: ready rises 3 cycles after next_sample is sampled, value valid 1 cycle after ready.
    assign i_sample_ready = up_ready;
    assign i_sample_value = up_valid ? cur_value : 16'h5A5A;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            up_ready <= 1'b1;
            up_valid <= 1'b1;
            up_cnt   <= 0;
        end else begin
            up_valid <= up_ready && !o_next_sample;
            if (o_next_sample) begin
                up_ready <= 1'b0;
                up_cnt   <= 3;
            end else if (up_cnt > 0) begin
                up_cnt <= up_cnt - 1;
                if (up_cnt == 1) up_ready <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected mixes on o_mix_valid and expected harmonic after each next_sample.
    initial begin
        logic ns_seen;
        logic [15:0] em;
        logic [7:0]  eh;
        ns_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ns_seen = 1'b0;
            end else begin
                if (o_mix_valid) begin
                    valid_cnt++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_mix_valid", 32'(o_mix), 32'hFFFF_FFFF);
                    end else begin
                        em = exp_q.pop_front();
                        check("mix", 32'(o_mix), 32'(em));
                    end
                end
                if (ns_seen) begin
                    if (harm_q.size() == 0) begin
                        check("unexpected_next_sample", 32'(o_harmonic), 32'hFFFF_FFFF);
                    end else begin
                        eh = harm_q.pop_front();
                        check("harmonic_step", 32'(o_harmonic), 32'(eh));
                    end
                end
                if (o_overrun) overrun_cnt++;
                ns_seen = o_next_sample;
            end
        end
    end

    task automatic start_frame(input logic [7:0] count, input logic [7:0] decay,
                               input logic [15:0] value, input logic [15:0] exp_mix);
        for (int h = 1; h <= int'(count); h++) harm_q.push_back(8'(h));
        harm_q.push_back(8'd0);
        exp_q.push_back(exp_mix);
        @(posedge clk);
        #1;
        cur_value        = value;
        i_harmonic_count = count;
        i_decay          = decay;
        i_sample_tick    = 1'b1;
        @(posedge clk);
        #1;
        i_sample_tick = 1'b0;
    endtask

    task automatic wait_done(input string name, input int start_valid);
        int n;
        n = 0;
        while (valid_cnt == start_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, 32'(n >= 1000), 32'd0);
        check({name, "_busy_after"}, 32'(o_busy), 32'd0);
        repeat (6) @(negedge clk);
        check({name, "_valid_pulses"}, 32'(valid_cnt - start_valid), 32'd1);
    endtask

    task automatic wait_harmonic(input logic [7:0] h);
        int n;
        n = 0;
        while (o_harmonic !== h && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("wait_harmonic_timeout", 32'(n >= 500), 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_harmonic"}, 32'(o_harmonic), 32'd0);
        check({name, "_next_sample"}, 32'(o_next_sample), 32'd0);
        check({name, "_mix"}, 32'(o_mix), 32'd0);
        check({name, "_mix_valid"}, 32'(o_mix_valid), 32'd0);
        check({name, "_busy"}, 32'(o_busy), 32'd0);
        check({name, "_overrun"}, 32'(o_overrun), 32'd0);
    endtask

    initial begin
        int sv;
        int so;
        rst              = 1'b1;
        i_sample_tick    = 1'b0;
        i_harmonic_count = 8'd0;
        i_decay          = 8'd0;
        cur_value        = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // 1: fundamental only, 0x4000 * 255 >> 8 = 0x3FC0
        sv = valid_cnt;
        start_frame(8'd0, 8'd0, 16'h4000, 16'h3FC0);
        wait_done("t1", sv);

        // 2: levels 255,155,55,0 -> 4096*465 >> 8 = 7440 = 0x1D10
        sv = valid_cnt;
        start_frame(8'd3, 8'd100, 16'h1000, 16'h1D10);
        wait_done("t2", sv);

        // 3: 32767*1020 >> 8 = 130556 -> positive saturation
        sv = valid_cnt;
        start_frame(8'd3, 8'd0, 16'h7FFF, 16'h7FFF);
        wait_done("t3", sv);

        // 4: -32768*510 = -16711680 >> 8 = -65280 -> negative saturation
        sv = valid_cnt;
        start_frame(8'd1, 8'd0, 16'h8000, 16'h8000);
        wait_done("t4", sv);

        // 5: a tick mid-frame (with a different count) is flagged and ignored
        sv = valid_cnt;
        so = overrun_cnt;
        start_frame(8'd3, 8'd100, 16'h1000, 16'h1D10);
        wait_harmonic(8'd2);
        @(posedge clk);
        #1;
        i_harmonic_count = 8'd0;
        i_sample_tick    = 1'b1;
        @(posedge clk);
        #1;
        i_sample_tick = 1'b0;
        wait_done("t5", sv);
        check("t5_overrun_pulses", 32'(overrun_cnt - so), 32'd1);

        // 6: async reset mid-frame abandons it; no mix_valid for it
        sv = valid_cnt;
        for (int h = 1; h <= 3; h++) harm_q.push_back(8'(h));
        harm_q.push_back(8'd0);
        @(posedge clk);
        #1;
        cur_value        = 16'h1000;
        i_harmonic_count = 8'd3;
        i_decay          = 8'd100;
        i_sample_tick    = 1'b1;
        @(posedge clk);
        #1;
        i_sample_tick = 1'b0;
        wait_harmonic(8'd2);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("t6_async");
        harm_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_no_valid", 32'(valid_cnt - sv), 32'd0);
        sv = valid_cnt;
        start_frame(8'd0, 8'd0, 16'h4000, 16'h3FC0);
        wait_done("t6_after", sv);
        check("t6_mix_held", 32'(o_mix), 32'h3FC0);

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("harm_q_empty", 32'(harm_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/harmonic_mixer.md
Name: harmonic_mixer

Overview:
- Sequencer and accumulator directly downstream of the per-harmonic sample-position/sine stage.
- On each output-rate tick, it steps the upstream stage through harmonics 0..N. It uses the i_harmonic / i_next_sample handshake to do this.
- Each returned sine value is scaled by a decaying amplitude level and summed into a signed accumulator.
- One saturated 16-bit mixed sample is delivered per tick to the DAC/output stage.

Parameters:
- ACC_SHIFT, 8, arithmetic right shift applied to the 32-bit accumulator before saturation.
- MAX_HARMONIC, 255, upper clamp on the last harmonic index iterated.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_sample_tick  in  1  one-cycle strobe that starts a frame (output sample rate).
- i_harmonic_count  in  8  last harmonic index to sum (0 = fundamental only); latched at frame start.
- i_decay  in  8  amount the level drops per harmonic; latched at frame start.
- i_sample_ready  in  1  upstream sample-position-loaded flag.
- i_sample_value  in  16  upstream sine LUT output, signed two's complement.
- o_harmonic  out  8  harmonic index driven to upstream.
- o_next_sample  out  1  one-cycle pulse telling upstream the current value is consumed.
- o_mix  out  16  signed mixed sample, held between frames.
- o_mix_valid  out  1  one-cycle pulse when o_mix updates.
- o_busy  out  1  high from frame start until the OUTPUT state completes.
- o_overrun  out  1  one-cycle pulse when a tick arrives while busy.

Behaviour:
- Reset (async, active-high) sets every output to zero: o_harmonic=0, o_next_sample=0, o_mix=0, o_mix_valid=0, o_busy=0, o_overrun=0. It also clears the accumulator and level, and sends the state to IDLE.
- A reset mid-frame abandons the frame; no o_mix_valid pulse is produced for it.
- States: IDLE, WAIT_READY, WAIT_LUT, MAC, ADVANCE, OUTPUT.
- IDLE:
  - On i_sample_tick, latch last = min(i_harmonic_count, MAX_HARMONIC) and decay = i_decay.
  - Clear acc, set level=255, set o_busy=1, go to WAIT_READY.
  - o_harmonic is already 0.
- WAIT_READY: stay until i_sample_ready=1, then go to WAIT_LUT.
- WAIT_LUT: exactly one cycle. The upstream LUT output is registered one clock after ready rises, so i_sample_value is captured into sample_q at the end of this cycle.
- MAC:
  - acc <= acc + sign_extend(sample_q) * {0, level}.
  - The product is a 16-bit signed value times a 9-bit non-negative value, giving a 24-bit signed result.
  - acc is 32-bit signed. 256 × |product| < 2^31, so no overflow is possible.
- ADVANCE (exactly one cycle):
  - o_next_sample=1 for this cycle only.
  - Simultaneously, o_harmonic <= (o_harmonic==last) ? 0 : o_harmonic+1.
  - level <= (level > decay) ? level-decay : 0, saturating at 0.
  - Then go to OUTPUT if the harmonic just finished was last, otherwise WAIT_READY.
  - i_sample_ready is not sampled in ADVANCE, because upstream deasserts it on the edge that samples o_next_sample.
  - o_harmonic is stable from ADVANCE until the next ADVANCE.
- All harmonics 0..last are always stepped, even once level=0. This keeps upstream phase accumulators coherent.
- OUTPUT:
  - o_mix <= saturate16(acc >>> ACC_SHIFT), clamped to 0x7FFF / 0x8000.
  - o_mix_valid=1 for one cycle, o_busy <= 0, go to IDLE.
  - Upstream has by then begun pre-computing harmonic 0 for the next frame.
- Overrun:
  - i_sample_tick in any state other than IDLE is ignored for frame control and gives o_overrun=1 next cycle.
  - The in-progress frame is unaffected.
  - A tick arriving in the same cycle as OUTPUT is also an overrun.
- Mixer-side cost per harmonic: WAIT_LUT + MAC + ADVANCE = 3 cycles, plus the upstream ready latency.

Decomposition:
- Shared package:
  - State encoding localparams.
  - Sample width (16), harmonic index width (8), level width (8), accumulator width (32).
  - LEVEL_INIT = 255.
- One natural sub-module: mix_saturate, a combinational arithmetic shift plus signed 32→16 saturation. It is reused by later output/filter stages.

Test Plan:
All tests use a bench upstream model that obeys the handshake: ready rises 3 cycles after it samples next_sample; value is valid 1 cycle after ready.
1. count=0, decay=0, value=0x4000, tick → o_harmonic stays 0, one next_sample pulse, o_mix=0x3FC0, one o_mix_valid pulse, o_busy low afterwards.
2. count=3, decay=100, value=0x1000 → o_harmonic sequence 1,2,3,0 on four next_sample pulses; levels 255,155,55,0; o_mix=0x1D10.
3. count=3, decay=0, value=0x7FFF → positive saturation, o_mix=0x7FFF.
4. count=1, decay=0, value=0x8000 → acc=-16711680, o_mix=0x8000 (negative saturation).
5. Tick reasserted at harmonic 2 of a count=3 frame → o_overrun single pulse, frame completes with the same o_mix as an undisturbed run, exactly one o_mix_valid.
6. Reset asserted asynchronously while o_harmonic=2 → all outputs 0 immediately, state IDLE. A following tick with count=0, value=0x4000 yields o_mix=0x3FC0.
